// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetch-side predictions checked against execute outcomes.
// Drives the predictor Jump update port and requests a redirect on misprediction.
module branch_resolve_unit #(
  parameter int P_DEPTH   = 8,
  parameter int P_DEPTH_N = 3
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iFLUSH,
  input  logic                 iPUSH_STB,
  input  logic                 iPUSH_PREDICT,
  input  logic [31:0]          iPUSH_PREDICT_ADDR,
  input  logic [31:0]          iPUSH_INST_ADDR,
  output logic                 oPUSH_FULL,
  output logic [P_DEPTH_N:0]   oCOUNT,
  input  logic                 iRESOLVE_STB,
  input  logic                 iRESOLVE_TAKEN,
  input  logic [31:0]          iRESOLVE_ADDR,
  output logic                 oJUMP_STB,
  output logic                 oJUMP_HIT,
  output logic [31:0]          oJUMP_ADDR,
  output logic [31:0]          oJUMP_INST_ADDR,
  output logic                 oMISPREDICT,
  output logic [31:0]          oREDIRECT_ADDR
);

  localparam logic [P_DEPTH_N:0] DEPTH_C = P_DEPTH[P_DEPTH_N:0];

  logic                 pred_q  [P_DEPTH];
  logic                 pred_d  [P_DEPTH];
  logic [31:0]          paddr_q [P_DEPTH];
  logic [31:0]          paddr_d [P_DEPTH];
  logic [31:0]          iaddr_q [P_DEPTH];
  logic [31:0]          iaddr_d [P_DEPTH];
  logic [P_DEPTH_N:0]   wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N:0]   rd_ptr_q, rd_ptr_d;
  logic                 jump_stb_q, jump_stb_d;
  logic                 jump_hit_q, jump_hit_d;
  logic [31:0]          jump_addr_q, jump_addr_d;
  logic [31:0]          jump_inst_q, jump_inst_d;
  logic                 mispred_q, mispred_d;
  logic [31:0]          redirect_q, redirect_d;

  logic [P_DEPTH_N:0]   count;
  logic                 empty;
  logic                 full;
  logic                 do_res;
  logic                 do_push;
  logic                 mispred;
  logic                 kill;
  logic                 head_pred;
  logic [31:0]          head_paddr;
  logic [31:0]          head_iaddr;
  logic [31:0]          correct_addr;

  always_comb begin
    count        = wr_ptr_q - rd_ptr_q;
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (count == DEPTH_C);
    head_pred    = pred_q[rd_ptr_q[P_DEPTH_N-1:0]];
    head_paddr   = paddr_q[rd_ptr_q[P_DEPTH_N-1:0]];
    head_iaddr   = iaddr_q[rd_ptr_q[P_DEPTH_N-1:0]];
    do_res       = iRESOLVE_STB && !empty;
    mispred      = (head_pred != iRESOLVE_TAKEN) ||
                   (head_pred && iRESOLVE_TAKEN && (head_paddr != iRESOLVE_ADDR));
    correct_addr = iRESOLVE_TAKEN ? iRESOLVE_ADDR : (head_iaddr + 32'd4);
    // A mispredict or flush discards everything younger, including a same-cycle push.
    kill         = iFLUSH || (do_res && mispred);
    // A correct resolve frees a slot this cycle, so a push is accepted even when full.
    do_push      = iPUSH_STB && !kill && (!full || do_res);

    rd_ptr_d = rd_ptr_q + {{P_DEPTH_N{1'b0}}, do_res};
    if (kill) begin
      wr_ptr_d = rd_ptr_d;
    end else begin
      wr_ptr_d = wr_ptr_q + {{P_DEPTH_N{1'b0}}, do_push};
    end

    pred_d  = pred_q;
    paddr_d = paddr_q;
    iaddr_d = iaddr_q;
    if (do_push) begin
      pred_d[wr_ptr_q[P_DEPTH_N-1:0]]  = iPUSH_PREDICT;
      paddr_d[wr_ptr_q[P_DEPTH_N-1:0]] = iPUSH_PREDICT_ADDR;
      iaddr_d[wr_ptr_q[P_DEPTH_N-1:0]] = iPUSH_INST_ADDR;
    end

    jump_stb_d  = do_res;
    jump_hit_d  = do_res && iRESOLVE_TAKEN;
    mispred_d   = do_res && mispred && !iFLUSH;
    jump_addr_d = jump_addr_q;
    jump_inst_d = jump_inst_q;
    redirect_d  = redirect_q;
    if (do_res) begin
      jump_addr_d = correct_addr;
      jump_inst_d = head_iaddr;
      redirect_d  = correct_addr;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      pred_q      <= '{default: '0};
      paddr_q     <= '{default: '0};
      iaddr_q     <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      jump_stb_q  <= 1'b0;
      jump_hit_q  <= 1'b0;
      jump_addr_q <= '0;
      jump_inst_q <= '0;
      mispred_q   <= 1'b0;
      redirect_q  <= '0;
    end else begin
      pred_q      <= pred_d;
      paddr_q     <= paddr_d;
      iaddr_q     <= iaddr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      jump_stb_q  <= jump_stb_d;
      jump_hit_q  <= jump_hit_d;
      jump_addr_q <= jump_addr_d;
      jump_inst_q <= jump_inst_d;
      mispred_q   <= mispred_d;
      redirect_q  <= redirect_d;
    end
  end

  assign oCOUNT          = count;
  assign oPUSH_FULL      = full;
  assign oJUMP_STB       = jump_stb_q;
  assign oJUMP_HIT       = jump_hit_q;
  assign oJUMP_ADDR      = jump_addr_q;
  assign oJUMP_INST_ADDR = jump_inst_q;
  assign oMISPREDICT     = mispred_q;
  assign oREDIRECT_ADDR  = redirect_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        push_stb;
  logic        push_pred;
  logic [31:0] push_paddr;
  logic [31:0] push_iaddr;
  logic        push_full;
  logic [3:0]  count;
  logic        res_stb;
  logic        res_taken;
  logic [31:0] res_addr;
  logic        jump_stb;
  logic        jump_hit;
  logic [31:0] jump_addr;
  logic [31:0] jump_inst;
  logic        mispredict;
  logic [31:0] redirect;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(.P_DEPTH(8), .P_DEPTH_N(3)) dut (
    .iCLOCK             (clk),
    .inRESET            (rst_n),
    .iFLUSH             (flush),
    .iPUSH_STB          (push_stb),
    .iPUSH_PREDICT      (push_pred),
    .iPUSH_PREDICT_ADDR (push_paddr),
    .iPUSH_INST_ADDR    (push_iaddr),
    .oPUSH_FULL         (push_full),
    .oCOUNT             (count),
    .iRESOLVE_STB       (res_stb),
    .iRESOLVE_TAKEN     (res_taken),
    .iRESOLVE_ADDR      (res_addr),
    .oJUMP_STB          (jump_stb),
    .oJUMP_HIT          (jump_hit),
    .oJUMP_ADDR         (jump_addr),
    .oJUMP_INST_ADDR    (jump_inst),
    .oMISPREDICT        (mispredict),
    .oREDIRECT_ADDR     (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush    = 1'b0;
    push_stb = 1'b0;
    res_stb  = 1'b0;
  endtask

  task automatic set_push(input logic p, input logic [31:0] tgt, input logic [31:0] pc);
    push_stb   = 1'b1;
    push_pred  = p;
    push_paddr = tgt;
    push_iaddr = pc;
  endtask

  task automatic set_res(input logic t, input logic [31:0] a);
    res_stb   = 1'b1;
    res_taken = t;
    res_addr  = a;
  endtask

  task automatic push1(input logic p, input logic [31:0] tgt, input logic [31:0] pc);
    idle();
    set_push(p, tgt, pc);
    cyc();
    idle();
  endtask

  task automatic res1(input logic t, input logic [31:0] a);
    idle();
    set_res(t, a);
    cyc();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    push_pred = 1'b0; push_paddr = '0; push_iaddr = '0;
    res_taken = 1'b0; res_addr = '0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(push_full), 32'd0);
    chk("rst_stb", 32'(jump_stb), 32'd0);
    chk("rst_mis", 32'(mispredict), 32'd0);
    chk("rst_redirect", redirect, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Correct taken prediction
    push1(1'b1, 32'h100, 32'h40);
    chk("t1_count1", 32'(count), 32'd1);
    res1(1'b1, 32'h100);
    chk("t1_stb", 32'(jump_stb), 32'd1);
    chk("t1_hit", 32'(jump_hit), 32'd1);
    chk("t1_addr", jump_addr, 32'h100);
    chk("t1_inst", jump_inst, 32'h40);
    chk("t1_mis", 32'(mispredict), 32'd0);
    chk("t1_count0", 32'(count), 32'd0);
    cyc();
    chk("t1_stb_pulse", 32'(jump_stb), 32'd0);

    // Predicted not-taken, actually taken
    push1(1'b0, 32'h0, 32'h80);
    res1(1'b1, 32'h200);
    chk("t2_mis", 32'(mispredict), 32'd1);
    chk("t2_redirect", redirect, 32'h200);
    chk("t2_hit", 32'(jump_hit), 32'd1);
    cyc();
    chk("t2_mis_pulse", 32'(mispredict), 32'd0);

    // Predicted taken, actually not taken
    push1(1'b1, 32'h300, 32'h90);
    res1(1'b0, 32'h0);
    chk("t3_mis", 32'(mispredict), 32'd1);
    chk("t3_redirect", redirect, 32'h94);
    chk("t3_addr", jump_addr, 32'h94);
    chk("t3_hit", 32'(jump_hit), 32'd0);

    // Fill, overflow, drain; twice to cross pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) push1(1'b1, 32'h1000 + 32'(i) * 16, 32'h2000 + 32'(i) * 4);
      chk("t4_full", 32'(push_full), 32'd1);
      chk("t4_count8", 32'(count), 32'd8);
      push1(1'b1, 32'h9999, 32'h3000);
      chk("t4_drop_count", 32'(count), 32'd8);
      for (int i = 0; i < 8; i++) begin
        res1(1'b1, 32'h1000 + 32'(i) * 16);
        chk("t4_stb", 32'(jump_stb), 32'd1);
        chk("t4_inst", jump_inst, 32'h2000 + 32'(i) * 4);
        chk("t4_mis", 32'(mispredict), 32'd0);
      end
      chk("t4_count0", 32'(count), 32'd0);
      chk("t4_notfull", 32'(push_full), 32'd0);
    end

    // Correct resolve with simultaneous push keeps count
    push1(1'b0, 32'h0, 32'hB0);
    idle();
    set_res(1'b0, 32'h0);
    set_push(1'b0, 32'h0, 32'hB4);
    cyc();
    idle();
    chk("t4b_inst", jump_inst, 32'hB0);
    chk("t4b_count", 32'(count), 32'd1);
    res1(1'b0, 32'h0);
    chk("t4b_inst2", jump_inst, 32'hB4);
    chk("t4b_addr2", jump_addr, 32'hB8);

    // Target mismatch with same-cycle wrong-path push
    push1(1'b1, 32'h500, 32'h50);
    push1(1'b1, 32'h600, 32'h54);
    push1(1'b1, 32'h700, 32'h58);
    chk("t5_count3", 32'(count), 32'd3);
    idle();
    set_res(1'b1, 32'h504);
    set_push(1'b1, 32'h800, 32'h5C);
    cyc();
    idle();
    chk("t5_mis", 32'(mispredict), 32'd1);
    chk("t5_redirect", redirect, 32'h504);
    chk("t5_count0", 32'(count), 32'd0);
    push1(1'b1, 32'hA00, 32'h60);
    res1(1'b1, 32'hA00);
    chk("t5_next_inst", jump_inst, 32'h60);
    chk("t5_next_mis", 32'(mispredict), 32'd0);

    // Resolve on empty is ignored
    res1(1'b1, 32'h123);
    chk("t6_empty_stb", 32'(jump_stb), 32'd0);
    chk("t6_empty_count", 32'(count), 32'd0);
    chk("t6_empty_inst", jump_inst, 32'h60);

    // Fall-through address wraps mod 2^32
    push1(1'b0, 32'h0, 32'hFFFF_FFFC);
    res1(1'b0, 32'h0);
    chk("t6_wrap_redirect", redirect, 32'h0);
    chk("t6_wrap_addr", jump_addr, 32'h0);
    chk("t6_wrap_mis", 32'(mispredict), 32'd0);

    // Flush with mispredicting resolve and push
    push1(1'b1, 32'hC00, 32'hC0);
    push1(1'b1, 32'hD00, 32'hC4);
    idle();
    flush = 1'b1;
    set_res(1'b0, 32'h0);
    set_push(1'b1, 32'hE00, 32'hC8);
    cyc();
    idle();
    chk("t7_stb", 32'(jump_stb), 32'd1);
    chk("t7_mis", 32'(mispredict), 32'd0);
    chk("t7_inst", jump_inst, 32'hC0);
    chk("t7_count", 32'(count), 32'd0);

    // Asynchronous reset mid-stream
    push1(1'b1, 32'hF00, 32'hF0);
    push1(1'b1, 32'hF10, 32'hF4);
    res1(1'b1, 32'h1234);
    chk("t8_pre_stb", 32'(jump_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_stb", 32'(jump_stb), 32'd0);
    chk("t8_mis", 32'(mispredict), 32'd0);
    chk("t8_count", 32'(count), 32'd0);
    chk("t8_addr", jump_addr, 32'h0);
    chk("t8_redirect", redirect, 32'h0);
    chk("t8_inst", jump_inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("t8_after_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
